// File: rtl/alt_vipswi131_switch_pkg.sv
// alt_vipswi131_switch_pkg: shared state encodings and register field layout for the switch control
package alt_vipswi131_switch_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } pkt_state_e;

   localparam int SEL_LSB = 0;

   function automatic int sel_width(input int no_inputs);
      return (no_inputs > 2) ? $clog2(no_inputs) : 1;
   endfunction

   function automatic int enable_bit(input int sel_w);
      return SEL_LSB + sel_w;
   endfunction

   function automatic int commit_index(input int no_outputs);
      return no_outputs;
   endfunction

endpackage

// File: rtl/alt_vipswi131_switch_output_ctrl.sv
// alt_vipswi131_switch_output_ctrl: per-output packet tracker that applies the shadow config between packets
module alt_vipswi131_switch_output_ctrl
   import alt_vipswi131_switch_pkg::*;
#(
   parameter int NO_INPUTS = 2,
   parameter int SEL_W     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_i,
   input  logic             pending_i,
   input  logic             commit_i,
   input  logic [SEL_W-1:0] shd_sel_i,
   input  logic             shd_en_i,
   input  logic             sop_i,
   input  logic             eop_i,
   output logic [SEL_W-1:0] sel_o,
   output logic             en_o,
   output logic             apply_o,
   output logic             applied_o,
   output logic             go_o,
   output logic             stopped_o
);

   localparam logic [SEL_W:0] NI = NO_INPUTS[SEL_W:0];

   pkt_state_e       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             en_q, en_d, applied_q, applied_d, in_range;

   // packet-boundary state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;

   // single-beat packets never leave idle; a stray sop mid-packet keeps the packet open
   always_comb
      state_d = (state_q == ST_IDLE) ? ((sop_i && !eop_i) ? ST_IN_PKT : ST_IDLE)
                                     : (eop_i ? ST_IDLE : ST_IN_PKT);

   // apply decision, out-of-range select squashing, and datapath permissions
   always_comb begin
      apply_o   = pending_i && !applied_q && (state_q == ST_IDLE) && !sop_i;
      in_range  = {1'b0, shd_sel_i} < NI;
      sel_d     = apply_o ? (in_range ? shd_sel_i : '0) : sel_q;
      en_d      = apply_o ? (shd_en_i && in_range) : en_q;
      applied_d = commit_i ? 1'b0 : (apply_o || applied_q);
      go_o      = enable_i && en_q && !(pending_i && !applied_q);
      stopped_o = !enable_i && (state_q == ST_IDLE);
   end

   // active configuration and applied flag; a fresh commit forces a re-apply
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sel_q     <= '0;
         en_q      <= 1'b0;
         applied_q <= 1'b0;
      end else begin
         sel_q     <= sel_d;
         en_q      <= en_d;
         applied_q <= applied_d;
      end

   assign sel_o     = sel_q;
   assign en_o      = en_q;
   assign applied_o = applied_q;

endmodule

// File: rtl/alt_vipswi131_switch_control.sv
// alt_vipswi131_switch_control: commit shadowing, per-output apply tracking and completion interrupt
module alt_vipswi131_switch_control
   import alt_vipswi131_switch_pkg::*;
#(
   parameter  int NO_INPUTS     = 2,
   parameter  int NO_OUTPUTS    = 1,
   parameter  int AV_DATA_WIDTH = 16,
   parameter  int NO_REGISTERS  = NO_OUTPUTS + 1,
   localparam int SEL_W         = sel_width(NO_INPUTS)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enable,
   input  logic [AV_DATA_WIDTH*NO_REGISTERS-1:0] registers,
   input  logic [NO_REGISTERS-1:0]             triggers,
   input  logic [NO_OUTPUTS-1:0]               out_sop,
   input  logic [NO_OUTPUTS-1:0]               out_eop,
   output logic [NO_OUTPUTS*SEL_W-1:0]         out_sel,
   output logic [NO_OUTPUTS-1:0]               out_en,
   output logic [NO_OUTPUTS-1:0]               go,
   output logic [NO_OUTPUTS-1:0]               stopped,
   output logic                                interrupts
);

   localparam int CI   = commit_index(NO_OUTPUTS);
   localparam int EN_B = enable_bit(SEL_W);

   logic                  commit, pending_q, pending_d, irq_q, irq_d, all_done, unused_bits;
   logic [NO_OUTPUTS-1:0] apply, applied, shd_en_q, shd_en_d;
   logic [SEL_W-1:0]      shd_sel_q [NO_OUTPUTS];
   logic [SEL_W-1:0]      shd_sel_d [NO_OUTPUTS];

   assign commit      = triggers[CI];
   assign unused_bits = ^{registers, triggers};

   // snapshot on commit; the last output to apply retires the commit and raises the interrupt
   always_comb begin
      all_done  = pending_q && &(applied | apply);
      pending_d = commit || (pending_q && !all_done);
      irq_d     = all_done && !commit;
      for (int k = 0; k < NO_OUTPUTS; k++) begin
         shd_sel_d[k] = commit ? registers[k*AV_DATA_WIDTH+SEL_LSB +: SEL_W] : shd_sel_q[k];
         shd_en_d[k]  = commit ? registers[k*AV_DATA_WIDTH+EN_B] : shd_en_q[k];
      end
   end

   // shadow, pending and interrupt registers; reset discards any in-flight commit
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
         shd_en_q  <= '0;
         shd_sel_q <= '{default: '0};
      end else begin
         pending_q <= pending_d;
         irq_q     <= irq_d;
         shd_en_q  <= shd_en_d;
         shd_sel_q <= shd_sel_d;
      end

   assign interrupts = irq_q;

   for (genvar g = 0; g < NO_OUTPUTS; g++) begin : g_out
      alt_vipswi131_switch_output_ctrl #(
         .NO_INPUTS (NO_INPUTS),
         .SEL_W     (SEL_W)
      ) u_ctrl (
         .clk       (clk),
         .rst       (rst),
         .enable_i  (enable),
         .pending_i (pending_q),
         .commit_i  (commit),
         .shd_sel_i (shd_sel_q[g]),
         .shd_en_i  (shd_en_q[g]),
         .sop_i     (out_sop[g]),
         .eop_i     (out_eop[g]),
         .sel_o     (out_sel[g*SEL_W +: SEL_W]),
         .en_o      (out_en[g]),
         .apply_o   (apply[g]),
         .applied_o (applied[g]),
         .go_o      (go[g]),
         .stopped_o (stopped[g])
      );
   end

endmodule

// File: tb/tb_alt_vipswi131_switch_control.sv
// tb_alt_vipswi131_switch_control: directed and randomized checks against a behavioural commit/apply model
module tb_alt_vipswi131_switch_control;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [47:0] registers = '0;
   logic [2:0]  triggers = '0;
   logic [1:0]  out_sop = '0, out_eop = '0;
   logic [3:0]  out_sel;
   logic [1:0]  out_en, go, stopped;
   logic        interrupts;

   int checks = 0, failures = 0, irq_cnt = 0;

   bit m_in_pkt [2];
   int m_sel    [2];
   bit m_en     [2];
   bit m_appl   [2];
   int m_word   [2];
   bit m_pend, m_irq;

   alt_vipswi131_switch_control #(
      .NO_INPUTS     (NI),
      .NO_OUTPUTS    (2),
      .AV_DATA_WIDTH (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .registers  (registers),
      .triggers   (triggers),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_sel    (out_sel),
      .out_en     (out_en),
      .go         (go),
      .stopped    (stopped),
      .interrupts (interrupts)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_in_pkt[k] = 0; m_sel[k] = 0; m_en[k] = 0; m_appl[k] = 0; m_word[k] = 0;
      end
      m_pend = 0;
      m_irq  = 0;
   endtask

   // one clock edge of the specification's rules, using the inputs held across the edge
   task automatic model_step();
      bit app [2];
      bit all_ok, commit;
      int s;
      commit = triggers[2];
      all_ok = m_pend;
      for (int k = 0; k < 2; k++) begin
         app[k] = m_pend && !m_appl[k] && !m_in_pkt[k] && !out_sop[k];
         all_ok = all_ok && (m_appl[k] || app[k]);
      end
      for (int k = 0; k < 2; k++) begin
         if (app[k]) begin
            s = m_word[k] % 4;
            m_sel[k] = (s < NI) ? s : 0;
            m_en[k]  = (s < NI) && ((m_word[k] / 4) % 2 == 1);
         end
         m_in_pkt[k] = m_in_pkt[k] ? !out_eop[k] : (out_sop[k] && !out_eop[k]);
      end
      m_irq = all_ok && !commit;
      if (commit) begin
         for (int k = 0; k < 2; k++) begin
            m_word[k] = int'(registers[k*16 +: 16]);
            m_appl[k] = 0;
         end
         m_pend = 1;
      end else begin
         for (int k = 0; k < 2; k++) m_appl[k] = m_appl[k] || app[k];
         if (all_ok) m_pend = 0;
      end
   endtask

   task automatic check_model();
      logic [1:0] eg, es, ee;
      for (int k = 0; k < 2; k++) begin
         eg[k] = enable && m_en[k] && !(m_pend && !m_appl[k]);
         es[k] = !enable && !m_in_pkt[k];
         ee[k] = m_en[k];
      end
      chk("out_sel", 32'(out_sel), 32'(m_sel[1] * 4 + m_sel[0]));
      chk("out_en", 32'(out_en), 32'(ee));
      chk("go", 32'(go), 32'(eg));
      chk("stopped", 32'(stopped), 32'(es));
      chk("interrupts", 32'(interrupts), 32'(m_irq));
   endtask

   // check the current cycle, then advance the DUT and the model across one edge
   task automatic cyc();
      if (rst) model_reset();
      #2;
      check_model();
      if (interrupts === 1'b1) irq_cnt++;
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      #1;
      triggers = '0;
      out_sop  = '0;
      out_eop  = '0;
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      cyc();
      chk("rst_out_en", 32'(out_en), 32'h0);
      chk("rst_go", 32'(go), 32'h0);
      chk("rst_stopped", 32'(stopped), 32'h3);
      chk("rst_irq", 32'(interrupts), 32'h0);
      rst = 1'b0;
      cyc();

      // basic commit with all outputs idle
      enable = 1'b1;
      registers = {16'h0000, 16'h0006, 16'h0005};
      triggers = 3'b100;
      cyc();
      chk("basic_c1_go", 32'(go), 32'h0);
      cyc();
      chk("basic_sel", 32'(out_sel), 32'h9);
      chk("basic_en", 32'(out_en), 32'h3);
      chk("basic_go", 32'(go), 32'h3);
      chk("basic_irq", 32'(interrupts), 32'h1);
      cyc();
      chk("basic_irq_once", 32'(interrupts), 32'h0);

      // deferred apply on an output that is mid-packet
      out_sop = 2'b10;
      cyc();
      registers = {16'h0000, 16'h0005, 16'h0004};
      triggers = 3'b100;
      cyc();
      cyc();
      chk("defer_sel0", 32'(out_sel[1:0]), 32'h0);
      chk("defer_sel1_old", 32'(out_sel[3:2]), 32'h2);
      chk("defer_go", 32'(go), 32'h1);
      cyc(); cyc(); cyc();
      out_eop = 2'b10;
      cyc();
      chk("defer_go1_low", 32'(go[1]), 32'h0);
      chk("defer_irq_wait", 32'(interrupts), 32'h0);
      cyc();
      chk("defer_sel", 32'(out_sel), 32'h4);
      chk("defer_go_new", 32'(go), 32'h3);
      chk("defer_irq", 32'(interrupts), 32'h1);

      // out-of-range select squashes the output
      registers = {16'h0000, 16'h0005, 16'h0007};
      triggers = 3'b100;
      cyc();
      cyc();
      chk("oor_sel", 32'(out_sel), 32'h4);
      chk("oor_en", 32'(out_en), 32'h2);
      chk("oor_go0", 32'(go[0]), 32'h0);
      chk("oor_irq", 32'(interrupts), 32'h1);
      cyc();

      // second commit while the first is still pending
      irq_cnt = 0;
      out_sop = 2'b10;
      cyc();
      registers = {16'h0000, 16'h0005, 16'h0006};
      triggers = 3'b100;
      cyc();
      cyc();
      registers = {16'h0000, 16'h0006, 16'h0001};
      triggers = 3'b100;
      cyc();
      cyc(); cyc();
      out_eop = 2'b10;
      for (int i = 0; i < 5; i++) cyc();
      chk("dbl_sel", 32'(out_sel), 32'h9);
      chk("dbl_en", 32'(out_en), 32'h2);
      chk("dbl_irq_cnt", 32'(irq_cnt), 32'h1);

      // enable dropped mid-packet, then reset mid-packet with a commit pending
      out_sop = 2'b01;
      cyc();
      enable = 1'b0;
      cyc(); cyc();
      chk("stop_in_pkt", 32'(stopped), 32'h2);
      out_eop = 2'b01;
      cyc();
      chk("stop_after_eop", 32'(stopped), 32'h3);
      enable = 1'b1;
      out_sop = 2'b10;
      cyc();
      registers = {16'h0000, 16'h0004, 16'h0005};
      triggers = 3'b100;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      irq_cnt = 0;
      for (int i = 0; i < 4; i++) cyc();
      chk("rst_mid_en", 32'(out_en), 32'h0);
      chk("rst_mid_irq_cnt", 32'(irq_cnt), 32'h0);

      // randomized traffic, commits and occasional resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) enable = !enable;
         if ($urandom_range(0, 5) == 0) begin
            registers[31:0]  = $urandom;
            registers[47:32] = 16'($urandom);
         end
         triggers[2] = ($urandom_range(0, 7) == 0);
         for (int k = 0; k < 2; k++) begin
            out_sop[k] = ($urandom_range(0, 3) == 0);
            out_eop[k] = ($urandom_range(0, 2) == 0);
         end
         rst = ($urandom_range(0, 149) == 0);
         cyc();
      end
      rst = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
